// File: rtl/izh_stim_strength_tracker_if.sv
// Event request / result handshake bundle for izh_stim_strength_tracker.
// The master side issues events and consumes results; the slave side is the tracker.
interface izh_stim_strength_tracker_if #(
    parameter int N_NEUR = 4,
    parameter int STR_W  = 4
);
    localparam int NW = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;

    logic             EVT_VALID;
    logic             EVT_READY;
    logic [NW-1:0]    EVT_NEUR;
    logic [1:0]       EVT_TYPE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [NW-1:0]    OUT_NEUR;
    logic [STR_W-1:0] OUT_STR;
    logic             STIM_GT_THR_EXC;
    logic             STIM_GT_THR_INH;
    logic             LONE_SPIKE_EXC;
    logic             LONE_SPIKE_INH;
    logic             STIM_ZERO;

    modport master (
        output EVT_VALID, EVT_NEUR, EVT_TYPE, OUT_READY,
        input  EVT_READY, OUT_VALID, OUT_NEUR, OUT_STR,
               STIM_GT_THR_EXC, STIM_GT_THR_INH,
               LONE_SPIKE_EXC, LONE_SPIKE_INH, STIM_ZERO
    );

    modport slave (
        input  EVT_VALID, EVT_NEUR, EVT_TYPE, OUT_READY,
        output EVT_READY, OUT_VALID, OUT_NEUR, OUT_STR,
               STIM_GT_THR_EXC, STIM_GT_THR_INH,
               LONE_SPIKE_EXC, LONE_SPIKE_INH, STIM_ZERO
    );
endinterface

// File: rtl/izh_stim_strength_tracker.sv
// Per-neuron stimulation-strength tracker with single-cycle read-modify-write and a registered result port.
// Define IZH_STIM_DECAY_EN to halve (toward zero) the pending strength on a time reference instead of clearing it.
module izh_stim_strength_tracker #(
    parameter int N_NEUR = 4,
    parameter int STR_W  = 4,
    parameter int HIST_D = 2
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [STR_W-2:0]          PARAM_STIM_THR,
    izh_stim_strength_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        EVT_EXC  = 2'b00,
        EVT_INH  = 2'b01,
        EVT_TREF = 2'b10,
        EVT_CLR  = 2'b11
    } evt_e;

    localparam logic signed [STR_W-1:0] ONE   = {{(STR_W-1){1'b0}}, 1'b1};
    localparam logic signed [STR_W-1:0] S_MAX = {1'b0, {(STR_W-1){1'b1}}};
    localparam logic signed [STR_W-1:0] S_MIN = {1'b1, {(STR_W-2){1'b0}}, 1'b1};

    // The committed strength is only ever observed on OUT_STR at the time reference
    // that produces it, so it is not kept as separate per-neuron state.
    logic signed [STR_W-1:0] tmp_q    [N_NEUR];
    logic [HIST_D-1:0]       hist_q   [N_NEUR];
    logic [1:0]              inhexc_q [N_NEUR];

    logic                    out_valid_q;
    logic [$bits(bus.OUT_NEUR)-1:0] out_neur_q;
    logic [STR_W-1:0]        out_str_q;
    logic [4:0]              out_flags_q;

    evt_e                    evt_type;
    logic                    accept;
    logic                    idx_ok;
    logic                    write_en;
    logic signed [STR_W-1:0] cur_tmp, nxt_tmp;
    logic [HIST_D-1:0]       cur_hist, nxt_hist;
    logic [1:0]              cur_inhexc, nxt_inhexc;
    logic [STR_W-1:0]        res_str;
    logic                    res_gt_exc, res_gt_inh, res_lone_exc, res_lone_inh, res_zero;

    function automatic logic gt_exc(input logic signed [STR_W-1:0] v, input logic [STR_W-2:0] thr);
        logic [STR_W:0] thr_x;
        thr_x = {2'b00, thr};
        return !v[STR_W-1] && ({v[STR_W-1], v} >= thr_x);
    endfunction

    function automatic logic gt_inh(input logic signed [STR_W-1:0] v, input logic [STR_W-2:0] thr);
        logic [STR_W:0] thr_x;
        logic [STR_W:0] mag;
        thr_x = {2'b00, thr};
        mag   = -{v[STR_W-1], v};
        return v[STR_W-1] && (mag >= thr_x);
    endfunction

    assign evt_type      = evt_e'(bus.EVT_TYPE);
    assign bus.EVT_READY = ~out_valid_q | bus.OUT_READY;
    assign accept        = bus.EVT_VALID & bus.EVT_READY;
    assign idx_ok        = int'(bus.EVT_NEUR) < N_NEUR;

    always_comb begin
        cur_tmp      = idx_ok ? tmp_q[bus.EVT_NEUR]    : '0;
        cur_hist     = idx_ok ? hist_q[bus.EVT_NEUR]   : '0;
        cur_inhexc   = idx_ok ? inhexc_q[bus.EVT_NEUR] : '0;
        nxt_tmp      = cur_tmp;
        nxt_hist     = cur_hist;
        nxt_inhexc   = cur_inhexc;
        write_en     = 1'b0;
        res_str      = '0;
        res_gt_exc   = 1'b0;
        res_gt_inh   = 1'b0;
        res_lone_exc = 1'b0;
        res_lone_inh = 1'b0;
        res_zero     = 1'b0;
        if (accept && idx_ok) begin
            write_en = 1'b1;
            case (evt_type)
                EVT_EXC: begin
                    if (cur_tmp != S_MAX) nxt_tmp = cur_tmp + ONE;
                    res_str = nxt_tmp;
                end
                EVT_INH: begin
                    if (cur_tmp != S_MIN) nxt_tmp = cur_tmp - ONE;
                    res_str = nxt_tmp;
                end
                EVT_TREF: begin
                    res_str      = cur_tmp;
                    res_zero     = (cur_tmp == '0);
                    res_lone_exc = res_zero && (cur_hist[HIST_D-1:1] == '0) && cur_inhexc[0];
                    res_lone_inh = res_zero && (cur_hist[HIST_D-1:1] == '0) && cur_inhexc[1];
                    res_gt_exc   = gt_exc(cur_tmp, PARAM_STIM_THR);
                    res_gt_inh   = gt_inh(cur_tmp, PARAM_STIM_THR);
                    nxt_hist     = {cur_hist[HIST_D-2:0], cur_tmp != '0};
                    nxt_inhexc   = {res_gt_inh, res_gt_exc};
`ifdef IZH_STIM_DECAY_EN
                    // Bias negatives by one so the arithmetic shift rounds toward zero.
                    nxt_tmp = cur_tmp[STR_W-1] ? ((cur_tmp + ONE) >>> 1) : (cur_tmp >>> 1);
`else
                    nxt_tmp = '0;
`endif
                end
                default: begin
                    nxt_tmp    = '0;
                    nxt_hist   = '0;
                    nxt_inhexc = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int unsigned i = 0; i < N_NEUR; i++) begin
                tmp_q[i]    <= '0;
                hist_q[i]   <= '0;
                inhexc_q[i] <= '0;
            end
        end else if (write_en) begin
            tmp_q[bus.EVT_NEUR]    <= nxt_tmp;
            hist_q[bus.EVT_NEUR]   <= nxt_hist;
            inhexc_q[bus.EVT_NEUR] <= nxt_inhexc;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            out_valid_q <= 1'b0;
            out_neur_q  <= '0;
            out_str_q   <= '0;
            out_flags_q <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_neur_q  <= bus.EVT_NEUR;
            out_str_q   <= res_str;
            out_flags_q <= {res_gt_exc, res_gt_inh, res_lone_exc, res_lone_inh, res_zero};
        end else if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.OUT_VALID       = out_valid_q;
    assign bus.OUT_NEUR        = out_neur_q;
    assign bus.OUT_STR         = out_str_q;
    assign bus.STIM_GT_THR_EXC = out_flags_q[4];
    assign bus.STIM_GT_THR_INH = out_flags_q[3];
    assign bus.LONE_SPIKE_EXC  = out_flags_q[2];
    assign bus.LONE_SPIKE_INH  = out_flags_q[1];
    assign bus.STIM_ZERO       = out_flags_q[0];
endmodule
